agc_multi: RTL and testbench
============================

# agc_multi

Multi-channel, parametrised successor to the single-channel AGC gain loop. Accepts time-multiplexed output-level samples (`vout`) tagged with a channel index, compares each against a per-channel reference held in a configuration register file, and updates a per-channel gain register. The update is either a fixed step or proportional to the error, and is saturated to a programmable range. Sits between the per-channel level detector and the variable-gain stage. Valid/ready on input and output.

## Interface
- `W`, 19, data/gain width (unsigned)
- `NCH`, 4, channel count (≥2); `CW = $clog2(NCH)`
- `SHIFT`, 4, proportional-mode right shift of error
- `GAIN_INIT`, `19'h10000`, per-channel gain after reset
- `GMIN`, 0, lower gain clamp
- `GMAX`, `2**W-1`, upper gain clamp (GMIN ≤ GAIN_INIT ≤ GMAX)

- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  sample valid
- `in_ready`  out  1  sample accepted when valid&ready
- `in_ch`  in  CW  channel of sample
- `in_vout`  in  W  measured output level
- `delta`  in  W  step size (step mode)
- `mode`  in  1  0 = step, 1 = proportional; sampled with each accepted sample
- `cfg_we`  in  1  write reference register
- `cfg_ch`  in  CW  channel written
- `cfg_vref`  in  W  reference value
- `out_valid`  out  1  updated gain valid
- `out_ready`  in  1  consumer ready
- `out_ch`  out  CW  channel of result
- `out_gain`  out  W  new gain of that channel
- `deadband`  in  W  present only with `AGC_DEADBAND_EN`

## Operation
- State: `gain[NCH]`, `vref[NCH]`, stage-1 reg (`s1_valid`, ch, vout, mode, delta), stage-2/output reg.
- `err = vref[ch] - vout`, signed W+1 bits, computed from the stage-1 register when it transfers to stage 2.
- Step mode: `err>0` → `gain+delta`; `err<0` → `gain-delta`; `err==0` → unchanged.
- Proportional mode: `gain + (err >>> SHIFT)`, arithmetic shift, sign-extended.
- Sums are computed in W+2 signed bits, then clamped to [GMIN, GMAX]. No wrap-around, ever.
- New gain is written to `gain[ch]` and loaded into the output register on the same edge (s1→s2 transfer). A later sample for the same channel therefore reads the updated value. Back-to-back same-channel samples are correct without forwarding.
- `cfg_we` writes `vref[cfg_ch]` at the clock edge. A sample already in stage 1 that transfers on that same edge uses the old vref. Stage-1 samples transferring on later edges use the new value.
- Out-of-range `in_ch`/`cfg_ch` (≥NCH): the sample completes with `out_gain` = 0 and no gain write; cfg writes are dropped.

## Timing
- Reset (async assert, sync deassert expected externally): `gain[*]=GAIN_INIT`, `vref[*]=0`, `s1_valid=0`, `out_valid=0`, `out_ch=0`, `out_gain=0`. `in_ready=1` while not stalled.
- Latency: accepted at edge t → `out_valid` high after edge t+1.
- `in_ready = !s1_valid | s2_adv`, where `s2_adv = !out_valid | out_ready` and s1 advances when `s2_adv`. Full throughput is one sample per cycle.
- `out_valid` low with `out_ready` anything: the output register may be overwritten.
- `out_valid&!out_ready`: both stages hold, no gain write, `out_*` stable.
- Reset mid-stream: both stages are flushed immediately; in-flight updates are lost and gains return to GAIN_INIT.

## Configuration
- `AGC_DEADBAND_EN` defined: `deadband` port exists. If `|err| ≤ deadband`, the gain is unchanged in both modes. The output is still produced.
- Not defined: port absent; behaviour as if deadband = 0, which leaves proportional mode and the step-mode `err==0` rule as above.

## Structure
- Package `agc_pkg`: `agc_mode_e` (STEP, PROP), and a clamp function.
- Sub-module `agc_update`: the combinational error, step/proportional, deadband and clamp datapath. It takes gain, vref, vout, delta, mode and deadband, and returns the new gain. It is instantiated once, in stage 1.

## Test plan
- Reset, then ch0 vref=100, vout=90, step, delta=16 → out_ch=0, out_gain=`0x10010` at latency 2; ch1 gain untouched (`0x10000`).
- Proportional mode, vref=0, vout=`0x100`, SHIFT=4 → gain `0x10000-0x10`=`0xFFF0`; with vout=`0x8`, err>>>4 gives −1 → `0xFFFF`.
- Clamp: step mode, delta=`0x7FFFF`, err>0 repeated → gain saturates at GMAX=`0x7FFFF`; err<0 → GMIN=0, no wrap.
- Same channel every cycle for 4 cycles, step mode +16, out_ready=1 → outputs `0x10010`, `0x10020`, `0x10030`, `0x10040` on consecutive cycles.
- out_ready low for 3 cycles with both stages full → in_ready=0, out_* stable, no gain change; then release → both results in order.
- With `AGC_DEADBAND_EN`, deadband=10, err=10 → gain unchanged; err=11 → +delta. Separately, assert reset_n mid-stream → out_valid=0 immediately, gains=GAIN_INIT.

Source files
------------

// File: rtl/agc_pkg.sv
// agc_pkg: shared types and helpers for the multi-channel AGC gain loop.
//   agc_mode_e : per-sample update mode (STEP = fixed delta, PROP = error-proportional)
//   CLAMP_W    : width of the generic signed clamp helper
//   clamp()    : saturate a signed value into [lo, hi]; callers sign-extend into
//                CLAMP_W bits and truncate the result back to their own width.
package agc_pkg;

    typedef enum logic {
        STEP = 1'b0,
        PROP = 1'b1
    } agc_mode_e;

    localparam int CLAMP_W = 64;

    function automatic logic signed [CLAMP_W-1:0] clamp(
        input logic signed [CLAMP_W-1:0] v,
        input logic signed [CLAMP_W-1:0] lo,
        input logic signed [CLAMP_W-1:0] hi
    );
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/agc_update.sv
// agc_update: combinational gain-update datapath for one sample.
//   gain, vref, vout, delta : W-bit unsigned operands
//   mode                    : STEP or PROP
//   deadband                : |err| at or below this leaves the gain unchanged
//   new_gain                : updated gain, saturated to [GMIN, GMAX]
// The error is vref - vout in W+1 signed bits; sums are formed in W+2 signed
// bits so neither gain+delta nor gain-delta can wrap before clamping.
module agc_update
    import agc_pkg::*;
#(
    parameter int             W     = 19,
    parameter int             SHIFT = 4,
    parameter logic [W-1:0]   GMIN  = '0,
    parameter logic [W-1:0]   GMAX  = {W{1'b1}}
) (
    input  logic [W-1:0] gain,
    input  logic [W-1:0] vref,
    input  logic [W-1:0] vout,
    input  logic [W-1:0] delta,
    input  agc_mode_e    mode,
    input  logic [W-1:0] deadband,
    output logic [W-1:0] new_gain
);

    logic signed [W:0]   err;
    logic signed [W:0]   err_sh;
    logic [W-1:0]        err_mag;
    logic                hold;
    logic signed [W+1:0] gain_s;
    logic signed [W+1:0] delta_s;
    logic signed [W+1:0] err_ext;
    logic signed [W+1:0] sum;

    always_comb begin
        err     = $signed({1'b0, vref}) - $signed({1'b0, vout});
        // Magnitude taken from the unsigned operands directly, so it always fits W bits.
        err_mag = err[W] ? (vout - vref) : (vref - vout);
        // A zero deadband still holds on err == 0, which is the step-mode rule.
        hold    = (err_mag <= deadband);
        err_sh  = err >>> SHIFT;
        err_ext = {err_sh[W], err_sh};
        gain_s  = $signed({2'b00, gain});
        delta_s = $signed({2'b00, delta});

        sum = gain_s;
        if (!hold) begin
            if (mode == PROP) begin
                sum = gain_s + err_ext;
            end else if (err[W]) begin
                sum = gain_s - delta_s;
            end else begin
                sum = gain_s + delta_s;
            end
        end

        new_gain = W'(clamp(CLAMP_W'(sum),
                            $signed(CLAMP_W'(GMIN)),
                            $signed(CLAMP_W'(GMAX))));
    end

endmodule

// File: rtl/agc_multi.sv
// agc_multi: time-multiplexed multi-channel AGC gain loop.
//   clk, reset_n (async, active low)
//   in_valid/in_ready, in_ch, in_vout, delta, mode : sample input (mode sampled per sample)
//   cfg_we, cfg_ch, cfg_vref                       : per-channel reference write
//   out_valid/out_ready, out_ch, out_gain          : updated gain of the sample's channel
//   deadband                                       : only when AGC_DEADBAND_EN is defined
// Two stages: stage 1 holds the accepted sample; on its transfer into the
// output register the new gain is computed and written back to gain[ch] on the
// same edge, so a following sample for the same channel already sees it.
// Optional feature macro: AGC_DEADBAND_EN.
module agc_multi
    import agc_pkg::*;
#(
    parameter int           W         = 19,
    parameter int           NCH       = 4,
    parameter int           SHIFT     = 4,
    parameter logic [W-1:0] GAIN_INIT = W'(32'h10000),
    parameter logic [W-1:0] GMIN      = '0,
    parameter logic [W-1:0] GMAX      = {W{1'b1}},
    localparam int          CW        = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_ch,
    input  logic [W-1:0]  in_vout,
    input  logic [W-1:0]  delta,
    input  logic          mode,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_ch,
    input  logic [W-1:0]  cfg_vref,
`ifdef AGC_DEADBAND_EN
    input  logic [W-1:0]  deadband,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_ch,
    output logic [W-1:0]  out_gain
);

    localparam logic [CW:0] NCH_V = (CW+1)'(NCH);

    logic          s1_valid_reg;
    logic [CW-1:0] s1_ch_reg;
    logic [W-1:0]  s1_vout_reg;
    logic [W-1:0]  s1_delta_reg;
    agc_mode_e     s1_mode_reg;

    logic          out_valid_reg;
    logic [CW-1:0] out_ch_reg;
    logic [W-1:0]  out_gain_reg;

    logic [W-1:0]  gain_reg [NCH];
    logic [W-1:0]  vref_reg [NCH];
    logic [NCH-1:0] gain_we;
    logic [NCH-1:0] vref_we;

    logic          s2_adv;
    logic          s1_xfer;
    logic          in_fire;
    logic          s1_in_range;
    logic [W-1:0]  cur_gain;
    logic [W-1:0]  cur_vref;
    logic [W-1:0]  deadband_eff;
    logic [W-1:0]  new_gain;

`ifdef AGC_DEADBAND_EN
    assign deadband_eff = deadband;
`else
    assign deadband_eff = '0;
`endif

    assign s2_adv      = !out_valid_reg | out_ready;
    assign in_ready    = !s1_valid_reg | s2_adv;
    assign in_fire     = in_valid & in_ready;
    assign s1_xfer     = s1_valid_reg & s2_adv;
    assign s1_in_range = ({1'b0, s1_ch_reg} < NCH_V);

    // Out-of-range channels read zeros; their result is forced to 0 below anyway.
    assign cur_gain = s1_in_range ? gain_reg[s1_ch_reg] : '0;
    assign cur_vref = s1_in_range ? vref_reg[s1_ch_reg] : '0;

    agc_update #(
        .W     (W),
        .SHIFT (SHIFT),
        .GMIN  (GMIN),
        .GMAX  (GMAX)
    ) u_update (
        .gain     (cur_gain),
        .vref     (cur_vref),
        .vout     (s1_vout_reg),
        .delta    (s1_delta_reg),
        .mode     (s1_mode_reg),
        .deadband (deadband_eff),
        .new_gain (new_gain)
    );

    // Per-channel write strobes; an out-of-range index matches no channel, so
    // such cfg writes and gain write-backs are simply dropped.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_we
            assign gain_we[gi] = s1_xfer & (s1_ch_reg == CW'(gi));
            assign vref_we[gi] = cfg_we & (cfg_ch == CW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                gain_reg[i] <= GAIN_INIT;
                vref_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (gain_we[i]) begin
                    gain_reg[i] <= new_gain;
                end
                // A stage-1 sample transferring on this edge has already used the old value.
                if (vref_we[i]) begin
                    vref_reg[i] <= cfg_vref;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_reg  <= 1'b0;
            s1_ch_reg     <= '0;
            s1_vout_reg   <= '0;
            s1_delta_reg  <= '0;
            s1_mode_reg   <= STEP;
            out_valid_reg <= 1'b0;
            out_ch_reg    <= '0;
            out_gain_reg  <= '0;
        end else begin
            if (in_fire) begin
                s1_valid_reg <= 1'b1;
                s1_ch_reg    <= in_ch;
                s1_vout_reg  <= in_vout;
                s1_delta_reg <= delta;
                s1_mode_reg  <= agc_mode_e'(mode);
            end else if (s2_adv) begin
                s1_valid_reg <= 1'b0;
            end

            if (s2_adv) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_ch_reg   <= s1_ch_reg;
                    out_gain_reg <= s1_in_range ? new_gain : '0;
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_ch    = out_ch_reg;
    assign out_gain  = out_gain_reg;

endmodule

// File: tb/tb_agc_multi.sv
// tb_agc_multi: directed literal checks plus randomized traffic for agc_multi.
// A behavioural model (per-channel gain/vref arrays and a queue of accepted
// samples) is advanced from the handshakes observed on each falling edge and
// compared with every new output. Optional feature macro: AGC_DEADBAND_EN.
module tb_agc_multi;

    localparam int     W     = 19;
    localparam int     NCH   = 4;
    localparam int     CW    = 2;
    localparam longint GMAXV = 64'h7FFFF;
    localparam longint GINIT = 64'h10000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ch = '0;
    logic [W-1:0]  in_vout = '0;
    logic [W-1:0]  delta = '0;
    logic          mode = 1'b0;
    logic          cfg_we = 1'b0;
    logic [CW-1:0] cfg_ch = '0;
    logic [W-1:0]  cfg_vref = '0;
    logic [W-1:0]  deadband = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] out_ch;
    logic [W-1:0]  out_gain;

    agc_multi dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_vout   (in_vout),
        .delta     (delta),
        .mode      (mode),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_vref  (cfg_vref),
`ifdef AGC_DEADBAND_EN
        .deadband  (deadband),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_gain  (out_gain)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int     ch;
        longint vout;
        longint dlt;
        bit     prop;
    } samp_t;

    samp_t       acc_q[$];
    longint      gain_m[NCH];
    longint      vref_m[NCH];
    bit          pend_we;
    int          pend_ch;
    longint      pend_vref;
    longint      db_prev;
    bit          prev_stall;
    logic [CW-1:0] prev_ch;
    logic [W-1:0]  prev_gain;

    function automatic longint model_update(longint g, longint vr, samp_t s, longint db);
        longint e;
        longint mag;
        longint r;
        e   = vr - s.vout;
        mag = (e < 0) ? -e : e;
        if (mag <= db) begin
            r = g;
        end else if (s.prop) begin
            // floor(e / 2**4)
            r = g + ((e >= 0) ? e / 16 : -((-e + 15) / 16));
        end else begin
            r = (e > 0) ? g + s.dlt : g - s.dlt;
        end
        if (r < 0) r = 0;
        if (r > GMAXV) r = GMAXV;
        return r;
    endfunction

    always @(negedge clk) begin
        samp_t  s;
        longint e_gain;
        bit     exp_ready;
        if (!reset_n) begin
            acc_q.delete();
            for (int i = 0; i < NCH; i++) begin
                gain_m[i] = GINIT;
                vref_m[i] = 0;
            end
            pend_we    = 1'b0;
            prev_stall = 1'b0;
            db_prev    = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_ch", out_ch, prev_ch);
                check("hold_gain", out_gain, prev_gain);
            end else if (out_valid) begin
                if (acc_q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 1'b0);
                end else begin
                    s = acc_q.pop_front();
                    e_gain = model_update(gain_m[s.ch], vref_m[s.ch], s, db_prev);
                    gain_m[s.ch] = e_gain;
                    check("out_ch", out_ch, s.ch);
                    check("out_gain", out_gain, e_gain);
                    $display("out ch=%0d vout=0x%0h mode=%0d gain=0x%0h (model 0x%0h)",
                             out_ch, s.vout, s.prop, out_gain, e_gain);
                end
            end
            exp_ready = !(out_valid && !out_ready && acc_q.size() > 0);
            check("in_ready", in_ready, exp_ready);
            // A cfg write seen one cycle ago landed on the edge that produced
            // this output, so it only becomes visible to later transfers.
            if (pend_we) vref_m[pend_ch] = pend_vref;
            pend_we   = cfg_we;
            pend_ch   = int'(cfg_ch);
            pend_vref = longint'(cfg_vref);
            if (in_valid && in_ready) begin
                acc_q.push_back('{ch: int'(in_ch), vout: longint'(in_vout),
                                  dlt: longint'(delta), prop: mode});
            end
            prev_stall = out_valid && !out_ready;
            prev_ch    = out_ch;
            prev_gain  = out_gain;
`ifdef AGC_DEADBAND_EN
            db_prev    = longint'(deadband);
`else
            db_prev    = 0;
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input longint v);
        cfg_we   = 1'b1;
        cfg_ch   = CW'(ch);
        cfg_vref = W'(v);
        tick();
        cfg_we   = 1'b0;
    endtask

    // Send one sample and check it appears one edge after acceptance.
    task automatic send_chk(input string name, input int ch, input longint vout,
                            input longint d, input bit prop, input longint req);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_ch    = CW'(ch);
        in_vout  = W'(vout);
        delta    = W'(d);
        mode     = prop;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        tick();
        check({name, "_valid"}, out_valid, 1'b1);
        check({name, "_ch"}, out_ch, ch);
        check({name, "_gain"}, out_gain, req);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_ch", out_ch, 0);
        check("rst_out_gain", out_gain, 0);
        check("rst_in_ready", in_ready, 1'b1);
        reset_n = 1'b1;
        tick();

        // Step mode, err = +10
        cfg(0, 100);
        send_chk("step_ch0", 0, 90, 16, 1'b0, 64'h10010);
        send_chk("ch1_untouched", 1, 0, 16, 1'b0, 64'h10000);

        // Proportional mode
        send_chk("prop_neg16", 2, 64'h100, 0, 1'b1, 64'hFFF0);
        send_chk("prop_neg1", 3, 64'h8, 0, 1'b1, 64'hFFFF);

        // Clamping at both ends
        cfg(1, 64'h40000);
        send_chk("clamp_hi1", 1, 0, 64'h7FFFF, 1'b0, 64'h7FFFF);
        send_chk("clamp_hi2", 1, 0, 64'h7FFFF, 1'b0, 64'h7FFFF);
        send_chk("clamp_lo1", 1, 64'h7FFFF, 64'h7FFFF, 1'b0, 64'h0);
        send_chk("clamp_lo2", 1, 64'h7FFFF, 64'h7FFFF, 1'b0, 64'h0);

        // Backpressure with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1; in_ch = 2'd0; in_vout = W'(90); delta = W'(16); mode = 1'b0;
        tick();
        in_ch = 2'd3; in_vout = W'(8); delta = '0; mode = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_valid", out_valid, 1'b1);
            check("stall_ch", out_ch, 0);
            check("stall_gain", out_gain, 64'h10020);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("release_ch", out_ch, 3);
        check("release_gain", out_gain, 64'hFFFE);
        tick();
        check("release_drained", out_valid, 1'b0);

`ifdef AGC_DEADBAND_EN
        deadband = W'(10);
        cfg(2, 100);
        send_chk("db_err10", 2, 90, 16, 1'b0, 64'hFFF0);
        send_chk("db_err11", 2, 89, 16, 1'b0, 64'h10000);
        deadband = '0;
`endif

        // Reset with both stages occupied
        cfg(2, 100);
        in_valid = 1'b1; in_ch = 2'd2; in_vout = W'(90); delta = W'(16); mode = 1'b0;
        tick();
        tick();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_gain", out_gain, 0);
        check("midrst_in_ready", in_ready, 1'b1);
        tick();
        reset_n = 1'b1;
        tick();
        send_chk("post_rst_gain", 2, 0, 16, 1'b0, GINIT);

        // Same channel on consecutive cycles
        cfg(2, 100);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                in_valid = 1'b1; in_ch = 2'd2; in_vout = W'(90); delta = W'(16); mode = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            if (i >= 2) begin
                check("b2b_valid", out_valid, 1'b1);
                check("b2b_gain", out_gain, GINIT + 16 * (i - 1));
            end
            tick();
        end
        tick();

        // Randomized traffic
        for (int c = 0; c < 1200; c++) begin
            in_valid = ($urandom_range(0, 99) < 60);
            in_ch    = CW'($urandom_range(0, NCH - 1));
            case ($urandom_range(0, 2))
                0:       in_vout = W'($urandom_range(0, 32'h7FFFF));
                1:       in_vout = W'($urandom_range(0, 300));
                default: in_vout = W'($urandom_range(32'h7FF00, 32'h7FFFF));
            endcase
            delta     = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 32'h7FFFF))
                                                    : W'($urandom_range(0, 64));
            mode      = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 99) < 70);
            cfg_we    = ($urandom_range(0, 9) == 0);
            cfg_ch    = CW'($urandom_range(0, NCH - 1));
            cfg_vref  = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 300))
                                                    : W'($urandom_range(0, 32'h7FFFF));
`ifdef AGC_DEADBAND_EN
            deadband  = W'($urandom_range(0, 20));
`endif
            if (c == 600) begin
                reset_n = 1'b0;
                #1;
                check("rand_rst_valid", out_valid, 1'b0);
            end
            if (c == 602) reset_n = 1'b1;
            tick();
        end

        in_valid  = 1'b0;
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        check("drain_out_valid", out_valid, 1'b0);
        check("drain_model_queue", acc_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
